// File: rtl/game_ctrl.sv
// Tic-tac-toe game controller: menu, side choice, play, line check and
// timed result screen, driven by mouse clicks and frame ticks.
module game_ctrl #(
   parameter int unsigned RESULT_FRAMES = 180
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic        mouse_left,
   input  logic        vsync_in,
   output logic        start_en,
   output logic        choice_en,
   output logic [17:0] board,
   output logic        turn,
   output logic [1:0]  winner,
   output logic        game_over
);

   localparam int CLOG = $clog2(RESULT_FRAMES + 1);
   localparam int CNT_W = (CLOG > 8) ? CLOG : 8;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(RESULT_FRAMES - 1);

   localparam logic [3:0] LN [8][3] = '{
      '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
   };

   typedef enum logic [2:0] {
      MENU, CHOICE, PLAY, CHECK, RESULT
   } state_t;

   state_t           state;
   logic             left_q;
   logic             vsync_q;
   logic [CNT_W-1:0] frame_cnt;

   logic       click;
   logic       tick;
   logic       col_ok;
   logic       row_ok;
   logic [1:0] col;
   logic [1:0] row;
   logic [3:0] cell_k;
   logic [4:0] cell_lsb;
   logic [1:0] cur_cell;
   logic       cell_hit;
   logic [1:0] c [9];
   logic       x_win;
   logic       o_win;
   logic       full;

   assign click = mouse_left & ~left_q;
   assign tick  = vsync_in & ~vsync_q;

   // Grid lines between cells and anything off the board are dead zones.
   always_comb begin
      col    = 2'd0;
      col_ok = 1'b1;
      if (mouse_xpos <= 12'd338)
         col = 2'd0;
      else if (mouse_xpos >= 12'd344 && mouse_xpos <= 12'd679)
         col = 2'd1;
      else if (mouse_xpos >= 12'd685 && mouse_xpos <= 12'd1023)
         col = 2'd2;
      else
         col_ok = 1'b0;
   end

   always_comb begin
      row    = 2'd0;
      row_ok = 1'b1;
      if (mouse_ypos <= 12'd251)
         row = 2'd0;
      else if (mouse_ypos >= 12'd259 && mouse_ypos <= 12'd507)
         row = 2'd1;
      else if (mouse_ypos >= 12'd515 && mouse_ypos <= 12'd767)
         row = 2'd2;
      else
         row_ok = 1'b0;
   end

   assign cell_k   = 4'(row) * 4'd3 + 4'(col);
   assign cell_lsb = {cell_k, 1'b0};
   assign cur_cell = board[cell_lsb +: 2];
   assign cell_hit = click & col_ok & row_ok;

   always_comb begin
      x_win = 1'b0;
      o_win = 1'b0;
      full  = 1'b1;
      for (int k = 0; k < 9; k++) begin
         c[k] = board[2*k +: 2];
         if (c[k] == 2'b00)
            full = 1'b0;
      end
      for (int l = 0; l < 8; l++) begin
         if (c[LN[l][0]] == 2'b01 && c[LN[l][1]] == 2'b01 &&
             c[LN[l][2]] == 2'b01)
            x_win = 1'b1;
         if (c[LN[l][0]] == 2'b10 && c[LN[l][1]] == 2'b10 &&
             c[LN[l][2]] == 2'b10)
            o_win = 1'b1;
      end
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state     <= MENU;
         left_q    <= 1'b0;
         vsync_q   <= 1'b0;
         frame_cnt <= '0;
         board     <= '0;
         turn      <= 1'b0;
         winner    <= 2'b00;
         start_en  <= 1'b0;
         choice_en <= 1'b0;
         game_over <= 1'b0;
      end else begin
         left_q  <= mouse_left;
         vsync_q <= vsync_in;
         unique case (state)
            MENU: begin
               if (click) begin
                  state     <= CHOICE;
                  board     <= '0;
                  winner    <= 2'b00;
                  start_en  <= 1'b1;
                  choice_en <= 1'b1;
               end
            end
            CHOICE: begin
               if (click) begin
                  turn      <= (mouse_xpos >= 12'd512);
                  state     <= PLAY;
                  choice_en <= 1'b0;
               end
            end
            PLAY: begin
               if (cell_hit && cur_cell == 2'b00) begin
                  board[cell_lsb +: 2] <= turn ? 2'b10 : 2'b01;
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (x_win || o_win || full) begin
                  winner    <= x_win ? 2'b01 : (o_win ? 2'b10 : 2'b11);
                  game_over <= 1'b1;
                  frame_cnt <= '0;
                  state     <= RESULT;
               end else begin
                  turn  <= ~turn;
                  state <= PLAY;
               end
            end
            RESULT: begin
               // Clicks are ignored here, so a coincident tick always wins.
               if (tick) begin
                  if (frame_cnt == LAST) begin
                     state     <= MENU;
                     frame_cnt <= '0;
                     board     <= '0;
                     winner    <= 2'b00;
                     turn      <= 1'b0;
                     start_en  <= 1'b0;
                     game_over <= 1'b0;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
            default: state <= MENU;
         endcase
      end
   end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed vector bench for game_ctrl: table of click/tick steps with
// hand-computed outputs, plus held-button and reset sequences.
module tb_game_ctrl;

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] mouse_xpos = '0;
   logic [11:0] mouse_ypos = '0;
   logic        mouse_left = 1'b0;
   logic        vsync_in = 1'b0;
   logic        start_en;
   logic        choice_en;
   logic [17:0] board;
   logic        turn;
   logic [1:0]  winner;
   logic        game_over;

   game_ctrl #(.RESULT_FRAMES(3)) dut (
      .pclk       (pclk),
      .rst_n      (rst_n),
      .mouse_xpos (mouse_xpos),
      .mouse_ypos (mouse_ypos),
      .mouse_left (mouse_left),
      .vsync_in   (vsync_in),
      .start_en   (start_en),
      .choice_en  (choice_en),
      .board      (board),
      .turn       (turn),
      .winner     (winner),
      .game_over  (game_over)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      int          x;
      int          y;
      bit          lf;
      bit          vs;
      logic [23:0] exp;
   } vec_t;

   localparam int HELD_AT = 20;

   vec_t rows[$];
   int   n_tests = 0;
   int   n_fail = 0;
   logic [23:0] act;

   assign act = {start_en, choice_en, game_over, turn, winner, board};

   function automatic logic [23:0] e(bit se, bit ce, bit go, bit t,
                                     logic [1:0] w, logic [17:0] b);
      return {se, ce, go, t, w, b};
   endfunction

   function automatic vec_t v(int x, int y, bit lf, bit vs,
                              logic [23:0] ex);
      vec_t r;
      r.x = x;
      r.y = y;
      r.lf = lf;
      r.vs = vs;
      r.exp = ex;
      return r;
   endfunction

   task automatic step(bit rn, int x, int y, bit l, bit vsx);
      @(negedge pclk);
      rst_n = rn;
      mouse_xpos = 12'(x);
      mouse_ypos = 12'(y);
      mouse_left = l;
      vsync_in = vsx;
      @(posedge pclk);
      #1;
   endtask

   task automatic check(string nm, logic [23:0] got, logic [23:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic held_seq();
      step(1, 500, 100, 1, 0);
      check("held_write", 24'({turn, board}), 24'({1'b1, 18'h00009}));
      repeat (9) step(1, 500, 100, 1, 0);
      check("held_no_repeat", act, e(1, 0, 0, 0, 2'b00, 18'h00009));
      step(1, 500, 100, 0, 0);
      check("held_release", act, e(1, 0, 0, 0, 2'b00, 18'h00009));
   endtask

   initial begin
      logic prev_go;
      // game 1: X wins on the top row
      rows.push_back(v(100, 100, 1, 0, e(1, 1, 0, 0, 0, 18'h0)));
      rows.push_back(v(100, 100, 1, 0, e(1, 0, 0, 0, 0, 18'h0)));
      rows.push_back(v(338, 251, 1, 0, e(1, 0, 0, 1, 0, 18'h00001)));
      rows.push_back(v(100, 400, 1, 0, e(1, 0, 0, 0, 0, 18'h00081)));
      rows.push_back(v(500, 100, 1, 0, e(1, 0, 0, 1, 0, 18'h00085)));
      rows.push_back(v(344, 259, 1, 0, e(1, 0, 0, 0, 0, 18'h00285)));
      rows.push_back(v(800, 100, 1, 0, e(1, 0, 1, 0, 1, 18'h00295)));
      rows.push_back(v(100, 700, 1, 0, e(1, 0, 1, 0, 1, 18'h00295)));
      rows.push_back(v(100, 700, 1, 1, e(1, 0, 1, 0, 1, 18'h00295)));
      rows.push_back(v(100, 700, 1, 1, e(1, 0, 1, 0, 1, 18'h00295)));
      rows.push_back(v(100, 700, 1, 1, e(0, 0, 0, 0, 0, 18'h0)));
      // game 2: dead-zone clicks, then a draw
      rows.push_back(v(100, 100, 1, 0, e(1, 1, 0, 0, 0, 18'h0)));
      rows.push_back(v(511, 100, 1, 0, e(1, 0, 0, 0, 0, 18'h0)));
      rows.push_back(v(100, 100, 1, 0, e(1, 0, 0, 1, 0, 18'h00001)));
      rows.push_back(v(341, 100, 1, 0, e(1, 0, 0, 1, 0, 18'h00001)));
      rows.push_back(v(100, 255, 1, 0, e(1, 0, 0, 1, 0, 18'h00001)));
      rows.push_back(v(1024, 100, 1, 0, e(1, 0, 0, 1, 0, 18'h00001)));
      rows.push_back(v(100, 768, 1, 0, e(1, 0, 0, 1, 0, 18'h00001)));
      rows.push_back(v(684, 400, 1, 0, e(1, 0, 0, 1, 0, 18'h00001)));
      rows.push_back(v(100, 100, 1, 0, e(1, 0, 0, 1, 0, 18'h00001)));
      rows.push_back(v(800, 100, 1, 0, e(1, 0, 0, 1, 0, 18'h00019)));
      rows.push_back(v(679, 507, 1, 0, e(1, 0, 0, 0, 0, 18'h00219)));
      rows.push_back(v(100, 400, 1, 0, e(1, 0, 0, 1, 0, 18'h00259)));
      rows.push_back(v(800, 400, 1, 0, e(1, 0, 0, 0, 0, 18'h00A59)));
      rows.push_back(v(500, 700, 1, 0, e(1, 0, 0, 1, 0, 18'h04A59)));
      rows.push_back(v(100, 700, 1, 0, e(1, 0, 0, 0, 0, 18'h06A59)));
      rows.push_back(v(800, 700, 1, 0, e(1, 0, 1, 0, 3, 18'h16A59)));
      rows.push_back(v(0, 0, 0, 1, e(1, 0, 1, 0, 3, 18'h16A59)));
      rows.push_back(v(0, 0, 0, 1, e(1, 0, 1, 0, 3, 18'h16A59)));
      rows.push_back(v(0, 0, 0, 1, e(0, 0, 0, 0, 0, 18'h0)));
      // game 3: O starts, four cells filled before reset
      rows.push_back(v(100, 100, 1, 0, e(1, 1, 0, 0, 0, 18'h0)));
      rows.push_back(v(512, 100, 1, 0, e(1, 0, 0, 1, 0, 18'h0)));
      rows.push_back(v(1023, 767, 1, 0, e(1, 0, 0, 0, 0, 18'h20000)));
      rows.push_back(v(338, 100, 1, 0, e(1, 0, 0, 1, 0, 18'h20001)));
      rows.push_back(v(500, 100, 1, 0, e(1, 0, 0, 0, 0, 18'h20009)));
      rows.push_back(v(685, 251, 1, 0, e(1, 0, 0, 1, 0, 18'h20019)));

      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("reset_state", act, 24'h0);
      step(1, 0, 0, 0, 0);
      check("idle_after_reset", act, 24'h0);

      for (int i = 0; i < rows.size(); i++) begin
         if (i == HELD_AT)
            held_seq();
         prev_go = game_over;
         step(1, rows[i].x, rows[i].y, rows[i].lf, rows[i].vs);
         if (rows[i].exp[21] && !prev_go)
            check($sformatf("row%0d_latency", i),
                  24'({game_over, board}),
                  24'({1'b0, rows[i].exp[17:0]}));
         step(1, rows[i].x, rows[i].y, 1'b0, 1'b0);
         check($sformatf("row%0d", i), act, rows[i].exp);
      end

      step(0, 500, 400, 1, 0);
      check("reset_midgame", act, 24'h0);
      step(1, 500, 400, 0, 0);
      check("menu_after_reset", act, 24'h0);
      step(1, 500, 400, 1, 0);
      step(1, 500, 400, 0, 0);
      check("first_click_menu", act, e(1, 1, 0, 0, 0, 18'h0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
